// File: rtl/seg_rx_decode_if.sv
// Segment-bus receive interface: raw 7-segment bus in, reassembled bytes out.
// master = bus source / byte consumer, slave = the decoder.
interface seg_rx_decode_if;
    logic [7:0] seg_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       pat_err;
    logic       overrun;

    modport master (
        output seg_in,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  pat_err,
        input  overrun
    );

    modport slave (
        input  seg_in,
        input  out_ready,
        output out_data,
        output out_valid,
        output pat_err,
        output overrun
    );
endinterface

// File: rtl/seg_rx_decode.sv
// Decodes a settled multiplexed 7-segment bus back into bytes with valid/ready output.
// Define SEG_RX_SYNC_EN to add a 2-flop synchronizer ahead of the input register.
//
// state   | meaning
// WAIT_LO | no partial byte held; waiting for a low-nibble glyph (digit select 0)
// WAIT_HI | low nibble latched; waiting for the high-nibble glyph (digit select 1)
module seg_rx_decode #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    seg_rx_decode_if.slave  bus
);
    localparam logic [7:0] SETTLE_SAT  = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic {WAIT_LO = 1'b0, WAIT_HI = 1'b1} state_t;

    state_t     state, state_next;
    logic [7:0] seg_src;
    logic [7:0] s_q, s_d;
    logic [7:0] cnt, cnt_next;
    logic       acc_flag, accept;
    logic       legal;
    logic [3:0] nib;
    logic [3:0] lo_nib, lo_next;
    logic       complete, err_next;
    logic [7:0] assembled;
    logic [7:0] data_q, data_next;
    logic       valid_q, valid_next;
    logic       err_q;
    logic       ovr_q, ovr_next;

`ifdef SEG_RX_SYNC_EN
    logic [7:0] sync1, sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
        end else begin
            sync1 <= bus.seg_in;
            sync2 <= sync1;
        end
    end

    assign seg_src = sync2;
`else
    assign seg_src = bus.seg_in;
`endif

    // cnt describes the run of s_d; s_q is one sample ahead so the change is seen early
    always_comb begin
        cnt_next = cnt;
        if (s_q != s_d)
            cnt_next = 8'd0;
        else if (cnt != SETTLE_SAT)
            cnt_next = cnt + 8'd1;
    end

    assign accept = (cnt == SETTLE_LAST) && !acc_flag;

    always_comb begin
        legal = 1'b1;
        nib   = 4'h0;
        case (s_d[6:0])
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h27: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        lo_next    = lo_nib;
        complete   = 1'b0;
        err_next   = 1'b0;
        assembled  = {nib, lo_nib};
        if (accept) begin
            if (!legal) begin
                err_next   = 1'b1;
                state_next = WAIT_LO;
            end else if (state == WAIT_LO) begin
                if (!s_d[7]) begin
                    lo_next    = nib;
                    state_next = WAIT_HI;
                end
            end else if (s_d[7]) begin
                complete   = 1'b1;
                state_next = WAIT_LO;
            end else begin
                lo_next = nib;
            end
        end
    end

    // A completed byte only replaces the held one if that one is leaving this cycle
    always_comb begin
        data_next  = data_q;
        valid_next = valid_q;
        ovr_next   = ovr_q;
        if (complete) begin
            if (!valid_q || bus.out_ready) begin
                data_next  = assembled;
                valid_next = 1'b1;
            end else begin
                ovr_next = 1'b1;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= WAIT_LO;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q      <= 8'h00;
            s_d      <= 8'h00;
            cnt      <= 8'd0;
            acc_flag <= 1'b0;
            lo_nib   <= 4'h0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            s_q      <= seg_src;
            s_d      <= s_q;
            cnt      <= cnt_next;
            acc_flag <= (s_q != s_d) ? 1'b0 : (acc_flag | accept);
            lo_nib   <= lo_next;
            data_q   <= data_next;
            valid_q  <= valid_next;
            err_q    <= err_next;
            ovr_q    <= ovr_next;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.pat_err   = err_q;
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_seg_rx_decode.sv
// Testbench for seg_rx_decode: directed sequences, a vector table and a randomized
// phase, all checked every cycle against a run-length reference model.
`timescale 1ns/1ps
module tb_seg_rx_decode;
    localparam int SETTLE = 4;
`ifdef SEG_RX_SYNC_EN
    localparam int PD = 4;
`else
    localparam int PD = 2;
`endif
    localparam int LAT = SETTLE + PD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_rx_decode_if bus();

    seg_rx_decode #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: a pattern counts once it has been seen SETTLE times in a row
    // at the end of a PD-deep sample delay; bytes are assembled from the glyph table.
    logic [7:0] pipe [PD];
    int         run_len;
    bit         m_have_lo;
    logic [3:0] m_lo;
    logic [7:0] e_data;
    logic       e_valid, e_err, e_ovr;
    bit         chk_en = 1'b0;

    function automatic int glyph_val(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (glyph[i] == p) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PD; i++) pipe[i] = 8'h00;
            run_len   = 1;
            m_have_lo = 1'b0;
            m_lo      = 4'h0;
            e_data    = 8'h00;
            e_valid   = 1'b0;
            e_err     = 1'b0;
            e_ovr     = 1'b0;
            chk_en    = 1'b1;
        end else begin
            logic [7:0] cur;
            logic [7:0] b;
            int         g;
            bit         cmpl;
            bit         take;
            cur   = pipe[PD-1];
            cmpl  = 1'b0;
            b     = 8'h00;
            take  = e_valid && bus.out_ready;
            e_err = 1'b0;
            if (run_len == SETTLE) begin
                g = glyph_val(cur[6:0]);
                if (g < 0) begin
                    e_err     = 1'b1;
                    m_have_lo = 1'b0;
                end else if (!cur[7]) begin
                    m_lo      = 4'(g);
                    m_have_lo = 1'b1;
                end else if (m_have_lo) begin
                    cmpl      = 1'b1;
                    b         = {4'(g), m_lo};
                    m_have_lo = 1'b0;
                end
            end
            if (cmpl) begin
                if (!e_valid || bus.out_ready) begin
                    e_data  = b;
                    e_valid = 1'b1;
                end else begin
                    e_ovr = 1'b1;
                end
            end else if (take) begin
                e_valid = 1'b0;
            end
            run_len = (pipe[PD-2] == cur) ? ((run_len > SETTLE) ? run_len : run_len + 1) : 1;
            for (int i = PD - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = bus.seg_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (bus.out_valid !== e_valid || bus.pat_err !== e_err ||
                bus.overrun !== e_ovr || bus.out_data !== e_data) begin
                n_bad++;
                $display("FAIL model t=%0t got v=%b d=%h err=%b ovr=%b want v=%b d=%h err=%b ovr=%b",
                         $time, bus.out_valid, bus.out_data, bus.pat_err, bus.overrun,
                         e_valid, e_data, e_err, e_ovr);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        while (bus.out_valid !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s got out_valid=%b want 1 within %0d cycles", name, bus.out_valid, budget);
        end
    endtask

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int         k;
        int         hold;
        logic [7:0] v;

        vecs[0] = '{8'h3F, 8'h86, 8'h10};
        vecs[1] = '{8'h4F, 8'hEF, 8'h93};
        vecs[2] = '{8'h7C, 8'hFD, 8'h6B};
        vecs[3] = '{8'h5E, 8'hFF, 8'h8D};
        vecs[4] = '{8'h27, 8'hB9, 8'hC7};
        vecs[5] = '{8'h71, 8'hBF, 8'h0F};
        vecs[6] = '{8'h7F, 8'hF9, 8'hE8};
        vecs[7] = '{8'h6F, 8'hA7, 8'h79};

        bus.seg_in    = 8'h06;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        tick(2);
        check("rst_valid", 8'(bus.out_valid), 8'h00);
        check("rst_data", bus.out_data, 8'h00);
        check("rst_err", 8'(bus.pat_err), 8'h00);
        check("rst_ovr", 8'(bus.overrun), 8'h00);
        rst = 1'b0;

        // basic byte and latency from the high pattern
        tick(6);
        bus.seg_in = 8'hDB;
        tick(LAT - 1);
        check("lat_early", 8'(bus.out_valid), 8'h00);
        tick(1);
        check("lat_valid", 8'(bus.out_valid), 8'h01);
        check("lat_data", bus.out_data, 8'h21);
        tick(1);
        check("pulse_once", 8'(bus.out_valid), 8'h00);

        // short-lived low glitch
        bus.seg_in = 8'h3F; tick(3);
        bus.seg_in = 8'h06; tick(6);
        bus.seg_in = 8'hF1;
        wait_valid("glitch_lo_valid", 2 * LAT);
        check("glitch_lo_data", bus.out_data, 8'hF1);
        tick(1);

        // short-lived high glitch would complete a wrong byte if accepted
        bus.seg_in = 8'h06; tick(LAT);
        bus.seg_in = 8'hBF; tick(SETTLE - 1);
        bus.seg_in = 8'h5B; tick(LAT);
        bus.seg_in = 8'hCF;
        wait_valid("glitch_hi_valid", 2 * LAT);
        check("glitch_hi_data", bus.out_data, 8'h32);
        tick(1);

        // illegal pattern aborts the partial byte
        bus.seg_in = 8'h79; tick(LAT);
        bus.seg_in = 8'h12;
        k = 0;
        while (bus.pat_err !== 1'b1 && k < 2 * LAT) begin tick(1); k++; end
        check("pat_err_pulse", 8'(bus.pat_err), 8'h01);
        tick(1);
        check("pat_err_one", 8'(bus.pat_err), 8'h00);
        bus.seg_in = 8'hFF; tick(2 * LAT);
        check("no_byte_after_err", 8'(bus.out_valid), 8'h00);
        bus.seg_in = 8'h06; tick(LAT);
        bus.seg_in = 8'hFF;
        wait_valid("after_err_valid", 2 * LAT);
        check("after_err_data", bus.out_data, 8'h81);
        tick(1);

        for (int i = 0; i < 8; i++) begin
            bus.seg_in = vecs[i].lo;
            tick(LAT);
            bus.seg_in = vecs[i].hi;
            wait_valid($sformatf("vec%0d_valid", i), 2 * LAT);
            check($sformatf("vec%0d_data", i), bus.out_data, vecs[i].exp);
            tick(1);
        end

        // last low nibble wins
        bus.seg_in = 8'h06; tick(LAT);
        bus.seg_in = 8'h5B; tick(LAT);
        bus.seg_in = 8'hE6;
        wait_valid("lo_over_valid", 2 * LAT);
        check("lo_over_data", bus.out_data, 8'h42);
        tick(1);

        // overrun while the consumer stalls
        bus.out_ready = 1'b0;
        bus.seg_in = 8'h6D; tick(LAT);
        bus.seg_in = 8'hF7;
        wait_valid("ovr_first_valid", 2 * LAT);
        check("ovr_first_data", bus.out_data, 8'hA5);
        bus.seg_in = 8'h39; tick(LAT);
        bus.seg_in = 8'hCF; tick(LAT + 1);
        check("ovr_hold_data", bus.out_data, 8'hA5);
        check("ovr_hold_valid", 8'(bus.out_valid), 8'h01);
        check("ovr_set", 8'(bus.overrun), 8'h01);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        check("ovr_consumed", 8'(bus.out_valid), 8'h00);
        check("ovr_sticky", 8'(bus.overrun), 8'h01);
        tick(4);
        check("ovr_sticky_later", 8'(bus.overrun), 8'h01);

        // reset while a byte is pending and a low nibble is held
        bus.seg_in = 8'h06; tick(LAT);
        bus.seg_in = 8'h86;
        wait_valid("rst_pend_valid", 2 * LAT);
        check("rst_pend_data", bus.out_data, 8'h11);
        bus.seg_in = 8'h5B; tick(LAT);
        rst = 1'b1;
        bus.seg_in = 8'hCF;
        tick(1);
        check("mid_rst_valid", 8'(bus.out_valid), 8'h00);
        check("mid_rst_data", bus.out_data, 8'h00);
        check("mid_rst_err", 8'(bus.pat_err), 8'h00);
        check("mid_rst_ovr", 8'(bus.overrun), 8'h00);
        rst = 1'b0;
        tick(3 * LAT);
        check("hi_only_no_byte", 8'(bus.out_valid), 8'h00);
        bus.out_ready = 1'b1;

        // randomized phase, checked by the model every cycle
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0)
                v = 8'($urandom_range(0, 255));
            else
                v = {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
            bus.seg_in = v;
            hold = $urandom_range(1, SETTLE + 3);
            for (int j = 0; j < hold; j++) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                if (i == 150 && j == 0) rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
        end

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end
endmodule
